lcd_cmd_responder: RTL and testbench

- Command-side endpoint of the LCD command interface, driven by the menu/display FSM.
- Accepts cmd_valid/cmd_type/cmd_data and runs the HD44780 4-bit power-on init sequence.
- Translates each command into PCF8574 expander bytes on a valid/ready byte port toward the I2C master.
- Enforces HD44780 execution delays and reports lcd_ready / lcd_init_done.

---
 rtl/lcd_cmd_responder.sv | 247 ++++++++++++++++++++++++
 tb/tb_lcd_cmd_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_responder.sv
// lcd_cmd_responder
// Command-side endpoint of the LCD command interface. This block accepts
// commands from the menu/display FSM, runs the HD44780 4-bit power-on init
// sequence, and turns each command into PCF8574 expander bytes on a
// valid/ready byte port toward the I2C master. It also enforces the
// HD44780 execution delays.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_valid          command strobe into the one-entry holding register
//   cmd_type[2:0]      0=INIT 1=CLEAR 2=WRITE_CMD 3=WRITE_DATA 4=SET_CURSOR
//   cmd_data[7:0]      command payload
//   lcd_ready          idle, holding register empty, init complete
//   lcd_init_done      init sequence completed
//   cmd_overrun        sticky: a command arrived while the holding reg was full
//   i2c_valid          expander byte valid
//   i2c_data[7:0]      {D7..D4, BL, EN, RW, RS}
//   i2c_ready          I2C master accepts the byte
//   backlight_on       only when LCD_BACKLIGHT_CTRL_EN is defined; it is
//                      sampled at the start of each command to drive BL.
//                      Without the macro, BL is constant 1.
//
// state      | meaning
// PWRON_WAIT | post-reset wait before the first init nibble
// INIT_STEP  | set up the next init-sequence entry
// NIB_EN_HI  | present current nibble with EN=1
// NIB_EN_LO  | present current nibble with EN=0
// DELAY      | HD44780 execution delay after the last byte of a command
// IDLE       | waiting for a held command
module lcd_cmd_responder #(
   parameter int PWRON_DLY_CYC = 5_000_000,
   parameter int INIT_DLY_CYC  = 410_000,
   parameter int SHORT_DLY_CYC = 5_000,
   parameter int LONG_DLY_CYC  = 200_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_type,
   input  logic [7:0] cmd_data,
`ifdef LCD_BACKLIGHT_CTRL_EN
   input  logic       backlight_on,
`endif
   output logic       lcd_ready,
   output logic       lcd_init_done,
   output logic       cmd_overrun,
   output logic       i2c_valid,
   output logic [7:0] i2c_data,
   input  logic       i2c_ready
);

   typedef enum logic [2:0] {
      PWRON_WAIT, INIT_STEP, NIB_EN_HI, NIB_EN_LO, DELAY, IDLE
   } state_t;

   typedef enum logic [1:0] {DLY_INIT, DLY_SHORT, DLY_LONG} dly_t;

   localparam logic [31:0] PWRON_LEN = 32'(PWRON_DLY_CYC - 1);
   localparam logic [31:0] INIT_LEN  = 32'(INIT_DLY_CYC - 1);
   localparam logic [31:0] SHORT_LEN = 32'(SHORT_DLY_CYC - 1);
   localparam logic [31:0] LONG_LEN  = 32'(LONG_DLY_CYC - 1);

   state_t      state, state_nx;
   dly_t        dly_r, dly_nx;
   logic [31:0] cnt, cnt_nx, dly_len;
   logic [2:0]  step, step_nx;
   logic        init_act, init_act_nx;
   logic [7:0]  byte_r, byte_nx;
   logic        rs_r, rs_nx, bl_r, bl_nx, low_r, low_nx, nib_only_r, nib_only_nx;
   logic        hold_valid, hold_valid_nx;
   logic [2:0]  hold_type, hold_type_nx;
   logic [7:0]  hold_data, hold_data_nx;
   logic        init_done_nx, overrun_nx, ready_nx, consume, bl_in;
   logic [3:0]  cur_nib;

`ifdef LCD_BACKLIGHT_CTRL_EN
   assign bl_in = backlight_on;
`else
   assign bl_in = 1'b1;
`endif

   assign cur_nib = low_r ? byte_r[3:0] : byte_r[7:4];

   always_comb begin
      case (dly_r)
         DLY_INIT: dly_len = INIT_LEN;
         DLY_LONG: dly_len = LONG_LEN;
         default:  dly_len = SHORT_LEN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= PWRON_WAIT;
         cnt           <= PWRON_LEN;
         step          <= '0;
         init_act      <= 1'b1;
         byte_r        <= '0;
         rs_r          <= 1'b0;
         bl_r          <= 1'b0;
         low_r         <= 1'b0;
         nib_only_r    <= 1'b0;
         dly_r         <= DLY_SHORT;
         hold_valid    <= 1'b0;
         hold_type     <= '0;
         hold_data     <= '0;
         lcd_init_done <= 1'b0;
         cmd_overrun   <= 1'b0;
         lcd_ready     <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         step          <= step_nx;
         init_act      <= init_act_nx;
         byte_r        <= byte_nx;
         rs_r          <= rs_nx;
         bl_r          <= bl_nx;
         low_r         <= low_nx;
         nib_only_r    <= nib_only_nx;
         dly_r         <= dly_nx;
         hold_valid    <= hold_valid_nx;
         hold_type     <= hold_type_nx;
         hold_data     <= hold_data_nx;
         lcd_init_done <= init_done_nx;
         cmd_overrun   <= overrun_nx;
         lcd_ready     <= ready_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      step_nx       = step;
      init_act_nx   = init_act;
      byte_nx       = byte_r;
      rs_nx         = rs_r;
      bl_nx         = bl_r;
      low_nx        = low_r;
      nib_only_nx   = nib_only_r;
      dly_nx        = dly_r;
      init_done_nx  = lcd_init_done;
      overrun_nx    = cmd_overrun;
      hold_valid_nx = hold_valid;
      hold_type_nx  = hold_type;
      hold_data_nx  = hold_data;
      consume       = 1'b0;
      i2c_valid     = 1'b0;
      i2c_data      = 8'h00;

      case (state)
         PWRON_WAIT: begin
            if (cnt == 32'd0) state_nx = INIT_STEP;
            else              cnt_nx   = cnt - 32'd1;
         end
         INIT_STEP: begin
            bl_nx       = bl_in;
            rs_nx       = 1'b0;
            low_nx      = 1'b0;
            nib_only_nx = (step < 3'd4);
            dly_nx      = DLY_SHORT;
            case (step)
               3'd0: begin byte_nx = 8'h30; dly_nx = DLY_INIT; end
               3'd1, 3'd2: byte_nx = 8'h30;
               3'd3: byte_nx = 8'h20;
               3'd4: byte_nx = 8'h28;
               3'd5: byte_nx = 8'h0C;
               3'd6: byte_nx = 8'h06;
               default: begin byte_nx = 8'h01; dly_nx = DLY_LONG; end
            endcase
            state_nx = NIB_EN_HI;
         end
         NIB_EN_HI: begin
            i2c_valid = 1'b1;
            i2c_data  = {cur_nib, bl_r, 1'b1, 1'b0, rs_r};
            if (i2c_ready) state_nx = NIB_EN_LO;
         end
         NIB_EN_LO: begin
            i2c_valid = 1'b1;
            i2c_data  = {cur_nib, bl_r, 1'b0, 1'b0, rs_r};
            if (i2c_ready) begin
               if (nib_only_r || low_r) begin
                  state_nx = DELAY;
                  cnt_nx   = dly_len;
               end else begin
                  low_nx   = 1'b1;
                  state_nx = NIB_EN_HI;
               end
            end
         end
         DELAY: begin
            if (cnt != 32'd0) begin
               cnt_nx = cnt - 32'd1;
            end else if (init_act && step != 3'd7) begin
               step_nx  = step + 3'd1;
               state_nx = INIT_STEP;
            end else begin
               if (init_act) init_done_nx = 1'b1;
               init_act_nx = 1'b0;
               state_nx    = IDLE;
            end
         end
         IDLE: begin
            if (hold_valid) begin
               consume     = 1'b1;
               bl_nx       = bl_in;
               low_nx      = 1'b0;
               nib_only_nx = 1'b0;
               rs_nx       = 1'b0;
               dly_nx      = DLY_SHORT;
               state_nx    = NIB_EN_HI;
               case (hold_type)
                  3'd0: begin
                     init_done_nx = 1'b0;
                     init_act_nx  = 1'b1;
                     step_nx      = '0;
                     state_nx     = INIT_STEP;
                  end
                  3'd1: begin byte_nx = 8'h01; dly_nx = DLY_LONG; end
                  3'd2: begin
                     byte_nx = hold_data;
                     if (hold_data[7:2] == 6'd0 && hold_data != 8'h00) dly_nx = DLY_LONG;
                  end
                  3'd3: begin byte_nx = hold_data; rs_nx = 1'b1; end
                  3'd4: byte_nx = {1'b1, hold_data[6:0]};
                  default: state_nx = IDLE;
               endcase
            end
         end
         default: state_nx = PWRON_WAIT;
      endcase

      // A slot freed by the command starting this cycle can be refilled at once.
      if (consume) hold_valid_nx = 1'b0;
      if (cmd_valid) begin
         if (!hold_valid || consume) begin
            hold_valid_nx = 1'b1;
            hold_type_nx  = cmd_type;
            hold_data_nx  = cmd_data;
         end else begin
            overrun_nx = 1'b1;
         end
      end

      ready_nx = (state_nx == IDLE) && !hold_valid_nx && init_done_nx;
   end

endmodule

// File: tb/tb_lcd_cmd_responder.sv
module tb_lcd_cmd_responder;

   localparam int PWRON = 20;
   localparam int INITD = 10;
   localparam int SHORT = 5;
   localparam int LONG  = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_type = 3'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       lcd_ready, lcd_init_done, cmd_overrun, i2c_valid;
   logic [7:0] i2c_data;
   logic       i2c_ready = 1'b1;

   int vectors = 0;
   int miscompares = 0;
   int bytes_seen = 0;
   logic [7:0] exp_q[$];

   lcd_cmd_responder #(
      .PWRON_DLY_CYC(PWRON), .INIT_DLY_CYC(INITD),
      .SHORT_DLY_CYC(SHORT), .LONG_DLY_CYC(LONG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
      .cmd_data(cmd_data), .lcd_ready(lcd_ready), .lcd_init_done(lcd_init_done),
      .cmd_overrun(cmd_overrun), .i2c_valid(i2c_valid), .i2c_data(i2c_data),
      .i2c_ready(i2c_ready)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted byte must be the next expected one.
   always @(negedge clk) begin
      if (rst_n && i2c_valid && i2c_ready) begin
         logic [7:0] e;
         vectors++;
         bytes_seen++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL unexpected_byte observed=%h expected=none", i2c_data);
         end else begin
            e = exp_q.pop_front();
            assert (i2c_data === e) else begin
               miscompares++;
               $error("FAIL i2c_byte observed=%h expected=%h", i2c_data, e);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_nib(input logic [3:0] n, input logic rs);
      exp_q.push_back({n, 1'b1, 1'b1, 1'b0, rs});
      exp_q.push_back({n, 1'b1, 1'b0, 1'b0, rs});
   endtask

   task automatic push_byte(input logic [7:0] b, input logic rs);
      push_nib(b[7:4], rs);
      push_nib(b[3:0], rs);
   endtask

   task automatic push_init;
      push_nib(4'h3, 1'b0);
      push_nib(4'h3, 1'b0);
      push_nib(4'h3, 1'b0);
      push_nib(4'h2, 1'b0);
      push_byte(8'h28, 1'b0);
      push_byte(8'h0C, 1'b0);
      push_byte(8'h06, 1'b0);
      push_byte(8'h01, 1'b0);
   endtask

   task automatic send(input logic [2:0] t, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_data  = d;
      tick;
      cmd_valid = 1'b0;
   endtask

   // Wait until the scoreboard holds at most 'target' entries.
   task automatic wait_q(input int target, input int budget, input string tag);
      int n = 0;
      while (exp_q.size() > target && n < budget) begin
         tick;
         n++;
      end
      vectors++;
      assert (exp_q.size() <= target) else begin
         miscompares++;
         $error("FAIL %s_timeout observed=%0d expected=%0d", tag, exp_q.size(), target);
      end
   endtask

   // Entered in the first cycle after the last byte is accepted.
   task automatic check_delay(input int n, input string tag);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (lcd_ready !== 1'b0 || i2c_valid !== 1'b0) bad++;
         tick;
      end
      chk({tag, "_quiet"}, 8'(bad), 8'd0);
      chk({tag, "_ready"}, {7'd0, lcd_ready}, 8'd1);
   endtask

   int base;

   initial begin
      tick;
      tick;
      chk("rst_ready", {7'd0, lcd_ready}, 8'd0);
      chk("rst_init_done", {7'd0, lcd_init_done}, 8'd0);
      chk("rst_overrun", {7'd0, cmd_overrun}, 8'd0);
      chk("rst_valid", {7'd0, i2c_valid}, 8'd0);
      chk("rst_data", i2c_data, 8'h00);

      // Power-on init
      push_init;
      rst_n = 1'b1;
      wait_q(0, 400, "init");
      check_delay(LONG, "init_delay");
      chk("init_done", {7'd0, lcd_init_done}, 8'd1);
      chk("init_bytes", 8'(bytes_seen), 8'd24);

      // WRITE_DATA 0x41
      push_byte(8'h41, 1'b1);
      send(3'd3, 8'h41);
      wait_q(0, 100, "wdata");
      check_delay(SHORT, "wdata_delay");

      // SET_CURSOR 0x40
      push_byte(8'hC0, 1'b0);
      send(3'd4, 8'h40);
      wait_q(0, 100, "cursor");
      check_delay(SHORT, "cursor_delay");

      // CLEAR
      push_byte(8'h01, 1'b0);
      send(3'd1, 8'h00);
      wait_q(0, 100, "clear");
      check_delay(LONG, "clear_delay");

      // WRITE_CMD boundaries: 0x02 long, 0x00 and 0x0F short
      push_byte(8'h02, 1'b0);
      send(3'd2, 8'h02);
      wait_q(0, 100, "wcmd02");
      check_delay(LONG, "wcmd02_delay");
      push_byte(8'h00, 1'b0);
      send(3'd2, 8'h00);
      wait_q(0, 100, "wcmd00");
      check_delay(SHORT, "wcmd00_delay");
      push_byte(8'h0F, 1'b0);
      send(3'd2, 8'h0F);
      wait_q(0, 100, "wcmd0f");
      check_delay(SHORT, "wcmd0f_delay");

      // Reserved type: consumed silently
      base = bytes_seen;
      send(3'd5, 8'hAA);
      chk("rsvd_busy", {7'd0, lcd_ready}, 8'd0);
      tick;
      chk("rsvd_ready", {7'd0, lcd_ready}, 8'd1);
      for (int i = 0; i < 5; i++) tick;
      chk("rsvd_bytes", 8'(bytes_seen - base), 8'd0);

      // Three back-to-back strobes: first runs, second held, third dropped
      chk("pre_overrun", {7'd0, cmd_overrun}, 8'd0);
      base = bytes_seen;
      push_byte(8'h41, 1'b1);
      push_byte(8'h42, 1'b1);
      cmd_valid = 1'b1;
      cmd_type  = 3'd3;
      cmd_data  = 8'h41;
      tick;
      cmd_data  = 8'h42;
      tick;
      cmd_data  = 8'h43;
      tick;
      cmd_valid = 1'b0;
      wait_q(0, 200, "burst");
      check_delay(SHORT, "burst_delay");
      chk("burst_overrun", {7'd0, cmd_overrun}, 8'd1);
      chk("burst_bytes", 8'(bytes_seen - base), 8'd8);

      // Back-pressure on the second byte
      push_byte(8'h41, 1'b1);
      send(3'd3, 8'h41);
      wait_q(3, 100, "stall_first");
      i2c_ready = 1'b0;
      begin
         int bad = 0;
         for (int i = 0; i < 7; i++) begin
            if (i2c_valid !== 1'b1 || i2c_data !== 8'h49) bad++;
            tick;
         end
         chk("stall_stable", 8'(bad), 8'd0);
      end
      i2c_ready = 1'b1;
      wait_q(0, 100, "stall_rest");
      check_delay(SHORT, "stall_delay");

      // INIT command reruns the sequence without the power-on wait
      push_init;
      send(3'd0, 8'h00);
      tick;
      chk("reinit_clear", {7'd0, lcd_init_done}, 8'd0);
      wait_q(0, 400, "reinit");
      check_delay(LONG, "reinit_delay");
      chk("reinit_done", {7'd0, lcd_init_done}, 8'd1);

      // Reset mid-command
      push_byte(8'h41, 1'b1);
      send(3'd3, 8'h41);
      wait_q(2, 100, "mid_cmd");
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {7'd0, lcd_ready}, 8'd0);
      chk("mid_rst_init_done", {7'd0, lcd_init_done}, 8'd0);
      chk("mid_rst_overrun", {7'd0, cmd_overrun}, 8'd0);
      chk("mid_rst_valid", {7'd0, i2c_valid}, 8'd0);
      chk("mid_rst_data", i2c_data, 8'h00);
      exp_q.delete();
      tick;
      base = bytes_seen;
      push_init;
      rst_n = 1'b1;
      wait_q(0, 400, "init2");
      check_delay(LONG, "init2_delay");
      chk("init2_done", {7'd0, lcd_init_done}, 8'd1);
      chk("init2_bytes", 8'(bytes_seen - base), 8'd24);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
